// File: rtl/control_unit_mc.sv
// -----------------------------------------------------------------------------
// control_unit_mc
//   Multicycle control FSM for the 64-bit RISC-V datapath (PC, IR, A/B, ALUOut,
//   MDR, register bank). It fetches and accesses data memory through req/ack
//   handshakes. A bounded wait-state timeout and illegal-opcode detection both
//   lead to a sticky TRAP state. It drives every datapath load enable and mux
//   select.
//
// Optional feature macro: PERF_CNT_EN
//   Defined:   adds cycle_cnt / instret_cnt performance counters (CNT_W bits).
//   Undefined: the counter ports and registers are absent.
//
// Ports
//   clock        in   rising-edge system clock
//   reset        in   asynchronous active-low reset
//   op           in   IR[6:0] opcode
//   funct3       in   IR[14:12]
//   funct7_5     in   IR[30] (selects SUB for R-type funct3=000)
//   zero         in   ALU zero flag
//   imem_req     out  instruction fetch request (held until imem_ack)
//   imem_ack     in   fetch data valid (may arrive in the request cycle)
//   dmem_req     out  data access request (held until dmem_ack)
//   dmem_we      out  1 = store
//   dmem_ack     in   data access done
//   pc_write     out  PC load enable
//   oldpc_load   out  OldPC <= PC
//   ir_load      out  IR <= instruction memory data
//   ab_load      out  A, B <= register bank outputs
//   aluout_load  out  ALUOut load enable
//   mdr_load     out  MDR <= data memory read data
//   rf_write     out  register bank write of rd
//   mux_a_sel    out  0=PC 1=A 2=OldPC
//   mux_b_sel    out  0=B 1=const 4 2=imm 3=imm<<1
//   wb_sel       out  0=ALUOut 1=MDR 2=imm (LUI) 3=PC
//   alu_sel      out  0=ADD 1=SUB 2=AND 3=OR 4=XOR
//   trap         out  sticky trap indication
//   trap_code    out  1=illegal opcode 2=memory timeout
//   busy         out  low only in the post-reset idle cycle and in TRAP
//   cycle_cnt    out  (PERF_CNT_EN) active non-trap cycles, wraps
//   instret_cnt  out  (PERF_CNT_EN) completed instructions, wraps
// -----------------------------------------------------------------------------
module control_unit_mc #(
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             pc_write,
    output logic             oldpc_load,
    output logic             ir_load,
    output logic             ab_load,
    output logic             aluout_load,
    output logic             mdr_load,
    output logic             rf_write,
    output logic [SEL_W-1:0] mux_a_sel,
    output logic [SEL_W-1:0] mux_b_sel,
    output logic [SEL_W-1:0] wb_sel,
    output logic [3:0]       alu_sel,
    output logic             trap,
    output logic [1:0]       trap_code,
    output logic             busy
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [SEL_W-1:0] A_PC     = SEL_W'(0);
    localparam logic [SEL_W-1:0] A_REG    = SEL_W'(1);
    localparam logic [SEL_W-1:0] A_OLDPC  = SEL_W'(2);
    localparam logic [SEL_W-1:0] B_REG    = SEL_W'(0);
    localparam logic [SEL_W-1:0] B_FOUR   = SEL_W'(1);
    localparam logic [SEL_W-1:0] B_IMM    = SEL_W'(2);
    localparam logic [SEL_W-1:0] B_IMM_SH = SEL_W'(3);
    localparam logic [SEL_W-1:0] WB_ALU   = SEL_W'(0);
    localparam logic [SEL_W-1:0] WB_MDR   = SEL_W'(1);
    localparam logic [SEL_W-1:0] WB_IMM   = SEL_W'(2);
    localparam logic [SEL_W-1:0] WB_PC    = SEL_W'(3);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_WB_ALU,
        S_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            armed;        // 0 only in the first cycle after reset release
    logic [6:0]      op_r;
    logic [2:0]      funct3_r;
    logic            funct7_5_r;
    logic [WC_W-1:0] wait_cnt;
    logic [1:0]      trap_cause;
    logic            mem_wait;
    logic            wait_expired;

    // R-type ALU function from the captured funct fields
    function automatic logic [3:0] r_alu_op(input logic [2:0] f3, input logic f7_5);
        case (f3)
            3'b000:  r_alu_op = f7_5 ? ALU_SUB : ALU_ADD;
            3'b111:  r_alu_op = ALU_AND;
            3'b110:  r_alu_op = ALU_OR;
            3'b100:  r_alu_op = ALU_XOR;
            default: r_alu_op = ALU_ADD;
        endcase
    endfunction

    // A request is outstanding and not satisfied in this cycle; a same-cycle
    // ack always beats the timeout.
    assign mem_wait     = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
    assign wait_expired = mem_wait && (wait_cnt == WC_W'(TIMEOUT - 1));

    // State register and captured instruction fields
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            armed      <= 1'b0;
            wait_cnt   <= '0;
            trap_code  <= TC_NONE;
            op_r       <= '0;
            funct3_r   <= '0;
            funct7_5_r <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= next_state;
            if (trap_cause != TC_NONE) begin
                trap_code <= trap_cause;
            end
            if (mem_wait && (next_state == state)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (state == S_DECODE) begin
                op_r       <= op;
                funct3_r   <= funct3;
                funct7_5_r <= funct7_5;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        trap_cause = TC_NONE;
        if (armed) begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        next_state = S_DECODE;
                    end else if (wait_expired) begin
                        next_state = S_TRAP;
                        trap_cause = TC_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_R:             next_state = S_EXEC_R;
                        OP_ADDI:          next_state = S_EXEC_I;
                        OP_LD, OP_SD:     next_state = S_ADDR;
                        OP_BEQ:           next_state = S_BRANCH;
                        OP_JAL:           next_state = S_JAL;
                        OP_LUI:           next_state = S_LUI;
                        default: begin
                            next_state = S_TRAP;
                            trap_cause = TC_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
                S_ADDR:   next_state = (op_r == OP_LD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD, S_MEM_WR: begin
                    if (dmem_ack) begin
                        next_state = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                    end else if (wait_expired) begin
                        next_state = S_TRAP;
                        trap_cause = TC_TIMEOUT;
                    end
                end
                S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_LUI: next_state = S_FETCH;
                S_TRAP:   next_state = S_TRAP;
                default:  next_state = S_TRAP;
            endcase
        end
    end

    // Output decode: requests and selects follow the state; load strobes that
    // complete a handshake are qualified by the matching ack.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_write    = 1'b0;
        oldpc_load  = 1'b0;
        ir_load     = 1'b0;
        ab_load     = 1'b0;
        aluout_load = 1'b0;
        mdr_load    = 1'b0;
        rf_write    = 1'b0;
        mux_a_sel   = A_PC;
        mux_b_sel   = B_REG;
        wb_sel      = WB_ALU;
        alu_sel     = ALU_ADD;
        trap        = (state == S_TRAP);
        busy        = armed && (state != S_TRAP);
        if (armed) begin
            case (state)
                S_FETCH: begin
                    imem_req   = 1'b1;
                    mux_a_sel  = A_PC;
                    mux_b_sel  = B_FOUR;
                    alu_sel    = ALU_ADD;
                    ir_load    = imem_ack;
                    oldpc_load = imem_ack;
                    pc_write   = imem_ack;
                end
                S_DECODE: begin
                    // Branch/jump target is precomputed here into ALUOut
                    ab_load     = 1'b1;
                    aluout_load = 1'b1;
                    mux_a_sel   = A_OLDPC;
                    mux_b_sel   = B_IMM_SH;
                    alu_sel     = ALU_ADD;
                end
                S_EXEC_R: begin
                    mux_a_sel   = A_REG;
                    mux_b_sel   = B_REG;
                    alu_sel     = r_alu_op(funct3_r, funct7_5_r);
                    aluout_load = 1'b1;
                end
                S_EXEC_I, S_ADDR: begin
                    mux_a_sel   = A_REG;
                    mux_b_sel   = B_IMM;
                    alu_sel     = ALU_ADD;
                    aluout_load = 1'b1;
                end
                S_WB_ALU: begin
                    rf_write = 1'b1;
                    wb_sel   = WB_ALU;
                end
                S_MEM_RD: begin
                    dmem_req = 1'b1;
                    mdr_load = dmem_ack;
                end
                S_WB_MEM: begin
                    rf_write = 1'b1;
                    wb_sel   = WB_MDR;
                end
                S_MEM_WR: begin
                    dmem_req = 1'b1;
                    dmem_we  = 1'b1;
                end
                S_BRANCH: begin
                    // Compare A-B; the target comes from ALUOut via the PC mux path
                    mux_a_sel = A_REG;
                    mux_b_sel = B_REG;
                    alu_sel   = ALU_SUB;
                    pc_write  = zero;
                end
                S_JAL: begin
                    // PC already holds OldPC+4, which becomes the link value
                    rf_write = 1'b1;
                    wb_sel   = WB_PC;
                    pc_write = 1'b1;
                end
                S_LUI: begin
                    rf_write = 1'b1;
                    wb_sel   = WB_IMM;
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic retire;

    // An instruction retires when a completing state hands back to FETCH
    assign retire = armed && (state != S_FETCH) && (next_state == S_FETCH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (retire) begin
                instret_cnt <= instret_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_control_unit_mc.sv
module tb_control_unit_mc;

    localparam int SEL_W   = 3;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [6:0]       op = '0;
    logic [2:0]       funct3 = '0;
    logic             funct7_5 = 1'b0;
    logic             zero = 1'b0;
    logic             imem_req, imem_ack = 1'b0;
    logic             dmem_req, dmem_we, dmem_ack = 1'b0;
    logic             pc_write, oldpc_load, ir_load, ab_load, aluout_load, mdr_load, rf_write;
    logic [SEL_W-1:0] mux_a_sel, mux_b_sel, wb_sel;
    logic [3:0]       alu_sel;
    logic             trap;
    logic [1:0]       trap_code;
    logic             busy;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

    logic [9:0]  strobes;
    logic [12:0] selects;
    assign strobes = {imem_req, dmem_req, dmem_we, pc_write, oldpc_load, ir_load,
                      ab_load, aluout_load, mdr_load, rf_write};
    assign selects = {mux_a_sel, mux_b_sel, wb_sel, alu_sel};

    control_unit_mc #(.SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_ack(dmem_ack), .pc_write(pc_write),
        .oldpc_load(oldpc_load), .ir_load(ir_load), .ab_load(ab_load),
        .aluout_load(aluout_load), .mdr_load(mdr_load), .rf_write(rf_write),
        .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel), .wb_sel(wb_sel),
        .alu_sel(alu_sel), .trap(trap), .trap_code(trap_code), .busy(busy)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected behaviour of one instruction, derived from the instruction rules
    typedef struct {
        int lat;     // total cycles FETCH..last state
        int n_pc;    // pc_write pulses
        int n_rf;    // rf_write pulses
        int n_mdr;   // mdr_load pulses
        int n_alo;   // aluout_load pulses
        int n_dreq;  // cycles with dmem_req high
        int n_we;    // cycles with dmem_req && dmem_we
        int wb;      // wb_sel at rf_write, -1 if none
        int alu;     // alu_sel at execute-stage aluout_load, -1 if none
        int ma;      // mux_a_sel there
        int mb;      // mux_b_sel there
    } exp_t;

    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input int iw, input int dw);
        exp_t e;
        e = '{lat: 0, n_pc: 1, n_rf: 0, n_mdr: 0, n_alo: 1, n_dreq: 0, n_we: 0,
              wb: -1, alu: -1, ma: -1, mb: -1};
        case (o)
            OP_R: begin
                e.lat = 4; e.n_rf = 1; e.wb = 0; e.n_alo = 2; e.ma = 1; e.mb = 0;
                case (f3)
                    3'b000:  e.alu = f7 ? 1 : 0;
                    3'b111:  e.alu = 2;
                    3'b110:  e.alu = 3;
                    3'b100:  e.alu = 4;
                    default: e.alu = 0;
                endcase
            end
            OP_ADDI: begin e.lat = 4; e.n_rf = 1; e.wb = 0; e.n_alo = 2; e.alu = 0; e.ma = 1; e.mb = 2; end
            OP_LD: begin
                e.lat = 5 + dw; e.n_rf = 1; e.wb = 1; e.n_mdr = 1; e.n_dreq = dw + 1;
                e.n_alo = 2; e.alu = 0; e.ma = 1; e.mb = 2;
            end
            OP_SD: begin
                e.lat = 4 + dw; e.n_dreq = dw + 1; e.n_we = dw + 1;
                e.n_alo = 2; e.alu = 0; e.ma = 1; e.mb = 2;
            end
            OP_BEQ: begin e.lat = 3; e.n_pc += (z ? 1 : 0); end
            OP_JAL: begin e.lat = 3; e.n_rf = 1; e.wb = 3; e.n_pc += 1; end
            OP_LUI: begin e.lat = 3; e.n_rf = 1; e.wb = 2; end
            default: ;
        endcase
        e.lat += iw;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ends one cycle after the release edge, at posedge+1, in the first live FETCH.
    task automatic do_reset();
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        imem_ack = 1'b1;      // ack without a request must be ignored
        #1;
        chk("idle strobes", strobes, 10'd0);
        chk("idle busy", busy, 1'b0);
        @(posedge clock);
        #1;
        imem_ack = 1'b0;
        chk("live fetch req", imem_req, 1'b1);
    endtask

    // Runs one instruction starting at posedge+1 of its FETCH cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int iw, input int dw);
        exp_t e;
        int cyc, ic, dc, n_ir, n_old, n_pc, n_rf, n_mdr, n_alo, n_dreq, n_we, n_idle;
        int wb_rf, alu_x, ma_x, mb_x, dec_bad, fet_bad;
        bit fetched;
        string t;
        e = model(o, f3, f7, z, iw, dw);
        op = o; funct3 = f3; funct7_5 = f7; zero = z;
        cyc = 0; ic = 0; dc = 0; n_ir = 0; n_old = 0; n_pc = 0; n_rf = 0; n_mdr = 0;
        n_alo = 0; n_dreq = 0; n_we = 0; n_idle = 0; dec_bad = 0; fet_bad = 0;
        wb_rf = -1; alu_x = -1; ma_x = -1; mb_x = -1; fetched = 0;
        while (cyc < 200) begin
            if (imem_req && fetched) break;
            imem_ack = imem_req ? (ic >= iw) : 1'($urandom_range(0, 1));
            dmem_ack = dmem_req ? (dc >= dw) : 1'($urandom_range(0, 1));
            if (imem_req) ic++;
            if (dmem_req) dc++;
            @(negedge clock);
            if (ir_load) begin
                fetched = 1;
                if (mux_a_sel != 0 || mux_b_sel != 1 || alu_sel != 0) fet_bad++;
            end
            n_ir  += int'(ir_load);
            n_old += int'(oldpc_load);
            n_pc  += int'(pc_write);
            n_rf  += int'(rf_write);
            n_mdr += int'(mdr_load);
            n_alo += int'(aluout_load);
            if (dmem_req) begin n_dreq++; n_we += int'(dmem_we); end
            if (rf_write) wb_rf = int'(wb_sel);
            if (ab_load && (mux_a_sel != 2 || mux_b_sel != 3 || alu_sel != 0 || !aluout_load)) dec_bad++;
            if (aluout_load && !ab_load) begin
                alu_x = int'(alu_sel); ma_x = int'(mux_a_sel); mb_x = int'(mux_b_sel);
            end
            if (!busy) n_idle++;
            @(posedge clock);
            #1;
            cyc++;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        t = $sformatf("op=%h f3=%0d iw=%0d dw=%0d", o, f3, iw, dw);
        chk({"latency ", t}, cyc, e.lat);
        chk({"ir_load ", t}, n_ir, 1);
        chk({"oldpc_load ", t}, n_old, 1);
        chk({"pc_write ", t}, n_pc, e.n_pc);
        chk({"rf_write ", t}, n_rf, e.n_rf);
        chk({"mdr_load ", t}, n_mdr, e.n_mdr);
        chk({"aluout_load ", t}, n_alo, e.n_alo);
        chk({"dmem_req cycles ", t}, n_dreq, e.n_dreq);
        chk({"dmem_we cycles ", t}, n_we, e.n_we);
        chk({"wb_sel ", t}, wb_rf, e.wb);
        chk({"alu_sel ", t}, alu_x, e.alu);
        chk({"mux_a exec ", t}, ma_x, e.ma);
        chk({"mux_b exec ", t}, mb_x, e.mb);
        chk({"decode sels ", t}, dec_bad, 0);
        chk({"fetch sels ", t}, fet_bad, 0);
        chk({"busy ", t}, n_idle, 0);
    endtask

    // Runs from posedge+1 of a FETCH until trap rises; data memory never acks.
    task automatic to_trap(input logic [6:0] o, input bit iack, output int ncyc, output int nreq);
        op = o; funct3 = 3'b011; funct7_5 = 1'b0; zero = 1'b0;
        ncyc = 0; nreq = 0;
        while (!trap && ncyc < 100) begin
            imem_ack = iack && imem_req;
            dmem_ack = 1'b0;
            if (imem_req || dmem_req) nreq++;
            @(posedge clock);
            #1;
            ncyc++;
        end
        imem_ack = 1'b0;
    endtask

    task automatic trap_hold(input string tag, input logic [1:0] code);
        chk({tag, " trap"}, trap, 1'b1);
        chk({tag, " trap_code"}, trap_code, code);
        chk({tag, " busy"}, busy, 1'b0);
        repeat (4) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            #1;
            chk({tag, " strobes"}, strobes, 10'd0);
            chk({tag, " selects"}, selects, 13'd0);
            @(posedge clock);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk({tag, " sticky"}, {trap, trap_code}, {1'b1, code});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, nr, k, iw, dw;
        logic [2:0] f3;

        // Reset state
        reset = 1'b0;
        #1;
        chk("reset strobes", strobes, 10'd0);
        chk("reset selects", selects, 13'd0);
        chk("reset trap", {trap, trap_code}, 3'd0);
        chk("reset busy", busy, 1'b0);
        do_reset();

        // Directed instructions
        run_instr(OP_R,   3'b000, 1'b0, 1'b0, 0, 0);   // ADD
        run_instr(OP_R,   3'b000, 1'b1, 1'b0, 0, 0);   // SUB
        run_instr(OP_LD,  3'b011, 1'b0, 1'b0, 0, 3);   // LD, ack after 3 waits
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);   // taken
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);   // not taken
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr(OP_SD,  3'b011, 1'b0, 1'b0, 2, 0);
        run_instr(OP_ADDI, 3'b000, 1'b0, 1'b0, TIMEOUT - 1, 0);  // ack on last allowed cycle
        run_instr(OP_SD,  3'b011, 1'b0, 1'b0, 0, TIMEOUT - 1);

        // Randomized instruction mix
        for (int n = 0; n < 40; n++) begin
            k  = int'($urandom_range(0, 6));
            iw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       f3 = 3'b000;
                1:       f3 = 3'b111;
                2:       f3 = 3'b110;
                default: f3 = 3'b100;
            endcase
            case (k)
                0:       run_instr(OP_R,    f3, 1'($urandom_range(0, 1)), 1'b0, iw, dw);
                1:       run_instr(OP_ADDI, f3, 1'b0, 1'b0, iw, dw);
                2:       run_instr(OP_LD,   3'b011, 1'b0, 1'b0, iw, dw);
                3:       run_instr(OP_SD,   3'b011, 1'b0, 1'b0, iw, dw);
                4:       run_instr(OP_BEQ,  3'b000, 1'b0, 1'($urandom_range(0, 1)), iw, dw);
                5:       run_instr(OP_JAL,  3'b000, 1'b0, 1'b0, iw, dw);
                default: run_instr(OP_LUI,  3'b000, 1'b0, 1'b0, iw, dw);
            endcase
        end

        // Illegal opcode: FETCH, DECODE, then TRAP code 1
        to_trap(7'h7F, 1'b1, nc, nr);
        chk("illegal cycles", nc, 2);
        chk("illegal req cycles", nr, 1);
        trap_hold("illegal", 2'd1);
        do_reset();

        // Fetch never acknowledged
        to_trap(OP_ADDI, 1'b0, nc, nr);
        chk("fetch timeout cycles", nc, TIMEOUT);
        chk("fetch timeout req cycles", nr, TIMEOUT);
        trap_hold("fetch timeout", 2'd2);
        do_reset();

        // Load whose data access is never acknowledged
        to_trap(OP_LD, 1'b1, nc, nr);
        chk("load timeout cycles", nc, 3 + TIMEOUT);
        chk("load timeout req cycles", nr, 1 + TIMEOUT);
        trap_hold("load timeout", 2'd2);
        do_reset();

        // Reset pulse in the middle of a data read wait
        op = OP_LD; funct3 = 3'b011; funct7_5 = 1'b0;
        nc = 0;
        while (!dmem_req && nc < 20) begin
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            @(posedge clock);
            #1;
            nc++;
        end
        imem_ack = 1'b0;
        chk("reached MEM_RD", dmem_req, 1'b1);
        repeat (2) begin @(posedge clock); #1; end
        #2;
        reset = 1'b0;
        #1;
        chk("async dmem_req drop", dmem_req, 1'b0);
        chk("async strobes", strobes, 10'd0);
        chk("async busy", busy, 1'b0);
        do_reset();
        run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);

`ifdef PERF_CNT_EN
        do_reset();
        for (int n = 0; n < 10; n++) run_instr(OP_ADDI, 3'b000, 1'b0, 1'b0, 0, 0);
        chk("instret_cnt", instret_cnt, CNT_W'(10));
        chk("cycle_cnt", cycle_cnt, CNT_W'(40));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
